sprite_scheduler: RTL

Arbitrates sprite-load requests from the game FSM and sequences the pixel loader one sprite at a time. It holds pending requests, picks one with background fixed-highest plus round-robin among the other seven, and drives the loader's 8-bit sprite-enable bus until the loader reports completion. It also supports display hold (blanking stall), a timeout watchdog and per-sprite completion acks.

---
 rtl/sprite_scheduler_if.sv | 27 ++
 rtl/sprite_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler_if.sv
// Request/loader bundle between the game FSM, the sprite scheduler and the pixel loader.
// LOAD_COUNT/TIMEOUT_COUNT carry data only when SPRITE_SCHED_STATS_EN is defined.
interface sprite_scheduler_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       REQ;
  logic             LOAD_DONE;
  logic             HOLD;
  logic             ERR_CLR;
  logic [7:0]       SPRITES_EN;
  logic             BUSY;
  logic [2:0]       GRANT_ID;
  logic [7:0]       ACK;
  logic             ERR;
  logic [CNT_W-1:0] LOAD_COUNT;
  logic [CNT_W-1:0] TIMEOUT_COUNT;

  modport master (
    output REQ, LOAD_DONE, HOLD, ERR_CLR,
    input  SPRITES_EN, BUSY, GRANT_ID, ACK, ERR, LOAD_COUNT, TIMEOUT_COUNT
  );

  modport slave (
    input  REQ, LOAD_DONE, HOLD, ERR_CLR,
    output SPRITES_EN, BUSY, GRANT_ID, ACK, ERR, LOAD_COUNT, TIMEOUT_COUNT
  );
endinterface

// File: rtl/sprite_scheduler.sv
// Sprite-load arbiter: background fixed-highest, round-robin over bits 0..6, one sprite at a time.
// Optional saturating load/timeout statistics are enabled with `define SPRITE_SCHED_STATS_EN.
module sprite_scheduler #(
  parameter int               CNT_W          = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 16'd65535
) (
  input logic               CLK,
  input logic               RESET_N,
  sprite_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, LOAD, RELEASE} state_t;

  localparam logic [CNT_W-1:0] LAST_TICK = TIMEOUT_CYCLES - CNT_W'(1);

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       pending_r;
  logic [2:0]       rr_ptr_r;
  logic [2:0]       grant_id_r;
  logic [CNT_W-1:0] timer_r;
  logic [7:0]       sprites_en_r;
  logic [7:0]       ack_r;
  logic             err_r;
  logic             busy_r;
  logic             grant_s;
  logic             done_s;
  logic             timeout_s;
  logic [2:0]       pick_s;

  function automatic logic [7:0] onehot8(input logic [2:0] id);
    onehot8 = 8'd1 << id;
  endfunction

  // Background wins outright; otherwise scan ascending from the sprite after the last winner.
  function automatic logic [2:0] pick_sprite(input logic [7:0] pend, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    pick_sprite = 3'd0;
    found       = 1'b0;
    if (pend[7]) begin
      pick_sprite = 3'd7;
    end else begin
      for (int k = 0; k < 7; k++) begin
        idx = 3'((int'(ptr) + 1 + k) % 7);
        if (!found && pend[idx]) begin
          pick_sprite = idx;
          found       = 1'b1;
        end
      end
    end
  endfunction

  assign pick_s = pick_sprite(pending_r, rr_ptr_r);

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Next-state and per-cycle event strobes.
  always_comb begin
    state_next_s = state_r;
    grant_s      = 1'b0;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r != 8'd0) begin
          state_next_s = GRANT;
          grant_s      = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT: state_next_s = LOAD;
      LOAD: begin
        if (bus.LOAD_DONE) begin
          done_s       = 1'b1;
          state_next_s = RELEASE;
        end else if (!bus.HOLD && (timer_r == LAST_TICK)) begin
          timeout_s    = 1'b1;
          state_next_s = RELEASE;
        end else begin
          state_next_s = LOAD;
        end
      end
      RELEASE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Pending set/clear (a new request beats the grant clear), grant capture and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_r  <= 8'd0;
      rr_ptr_r   <= 3'd6;
      grant_id_r <= 3'd0;
    end else begin
      pending_r <= (pending_r & ~(grant_s ? onehot8(pick_s) : 8'd0)) | bus.REQ;
      if (grant_s) begin
        grant_id_r <= pick_s;
        if (pick_s != 3'd7) rr_ptr_r <= pick_s;
      end
    end
  end

  // Load watchdog; HOLD cycles are not counted.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                           timer_r <= {CNT_W{1'b0}};
    else if (state_r == GRANT)              timer_r <= {CNT_W{1'b0}};
    else if (state_r == LOAD && !bus.HOLD)  timer_r <= timer_r + CNT_W'(1);
  end

  // Registered loader enable, completion ack, sticky error and busy flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sprites_en_r <= 8'd0;
      ack_r        <= 8'd0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      sprites_en_r <= (state_next_s == LOAD) ? (8'h80 | onehot8(grant_id_r)) : 8'd0;
      ack_r        <= done_s ? onehot8(grant_id_r) : 8'd0;
      busy_r       <= (state_next_s != IDLE);
      if (timeout_s)        err_r <= 1'b1;
      else if (bus.ERR_CLR) err_r <= 1'b0;
    end
  end

  // HOLD masks the loader's run bit without waiting for a clock edge.
  assign bus.SPRITES_EN = sprites_en_r & ~{bus.HOLD, 7'd0};
  assign bus.BUSY       = busy_r;
  assign bus.GRANT_ID   = grant_id_r;
  assign bus.ACK        = ack_r;
  assign bus.ERR        = err_r;

`ifdef SPRITE_SCHED_STATS_EN
  logic [CNT_W-1:0] load_count_r;
  logic [CNT_W-1:0] timeout_count_r;

  // Saturating completion and timeout counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_count_r    <= {CNT_W{1'b0}};
      timeout_count_r <= {CNT_W{1'b0}};
    end else begin
      if (done_s && load_count_r != {CNT_W{1'b1}})
        load_count_r <= load_count_r + CNT_W'(1);
      if (timeout_s && timeout_count_r != {CNT_W{1'b1}})
        timeout_count_r <= timeout_count_r + CNT_W'(1);
    end
  end

  assign bus.LOAD_COUNT    = load_count_r;
  assign bus.TIMEOUT_COUNT = timeout_count_r;
`else
  assign bus.LOAD_COUNT    = {CNT_W{1'b0}};
  assign bus.TIMEOUT_COUNT = {CNT_W{1'b0}};
`endif

endmodule
